// File: rtl/mkgauss_poly_ctrl.sv
// Gaussian-sampler sequencer: fills one small keygen polynomial (f or g) with range-checked
// coefficients, forces an odd coefficient sum on the last slot and writes them to coefficient RAM.
module mkgauss_poly_ctrl #(
   parameter int unsigned LOGN      = 9,
   parameter int unsigned COEF_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 gs_ena,
   input  logic                 gs_val_valid,
   input  logic [31:0]          gs_val,
   output logic                 coef_we,
   output logic [LOGN-1:0]      coef_addr,
   output logic [COEF_BITS-1:0] coef_wdata,
   output logic [15:0]          rej_cnt
);

   localparam int unsigned IW     = LOGN + 1;
   localparam int unsigned N      = 2 ** LOGN;
   localparam int          LIM_M1 = (2 ** (COEF_BITS - 1)) - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   index;
   logic            parity;

   logic signed [31:0] val_s;
   logic               range_bad;
   logic               last_idx;
   logic               parity_bad;
   logic               accept;

   // Acceptance decision for the sample currently on gs_val
   always_comb begin
      val_s      = $signed(gs_val);
      range_bad  = (val_s > LIM_M1) || (val_s < -LIM_M1);
      last_idx   = (index == IW'(N - 1));
      parity_bad = last_idx && ((parity ^ gs_val[0]) == 1'b0);
      accept     = !range_bad && !parity_bad;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         gs_ena     <= 1'b0;
         coef_we    <= 1'b0;
         coef_addr  <= '0;
         coef_wdata <= '0;
         rej_cnt    <= '0;
         index      <= '0;
         parity     <= 1'b0;
      end else begin
         coef_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state   <= S_RUN;
                  busy    <= 1'b1;
                  gs_ena  <= 1'b1;
                  index   <= '0;
                  parity  <= 1'b0;
                  rej_cnt <= '0;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state  <= S_IDLE;
                  busy   <= 1'b0;
                  gs_ena <= 1'b0;
               end else if (gs_val_valid && gs_ena) begin
                  if (!accept) begin
                     if (rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
                  end else begin
                     coef_we    <= 1'b1;
                     coef_addr  <= index[LOGN-1:0];
                     coef_wdata <= gs_val[COEF_BITS-1:0];
                     parity     <= parity ^ gs_val[0];
                     index      <= index + IW'(1);
                     // Final write: drop the sampler and raise done alongside it
                     if (last_idx) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        gs_ena <= 1'b0;
                        done   <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mkgauss_poly_ctrl.sv
// Self-checking bench for mkgauss_poly_ctrl: directed vector table on a LOGN=2 instance plus
// randomized runs on LOGN=2 and LOGN=9 instances checked against a plain-arithmetic model.
module tb_mkgauss_poly_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start2 = 1'b0;
   logic        start9 = 1'b0;
   logic        abort = 1'b0;
   logic        gs_val_valid = 1'b0;
   logic [31:0] gs_val = '0;

   logic        busy2, done2, ena2, we2;
   logic [1:0]  addr2;
   logic [7:0]  wdata2;
   logic [15:0] rej2;

   logic        busy9, done9, ena9, we9;
   logic [8:0]  addr9;
   logic [7:0]  wdata9;
   logic [15:0] rej9;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mkgauss_poly_ctrl #(.LOGN(2), .COEF_BITS(8)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort),
      .busy(busy2), .done(done2), .gs_ena(ena2),
      .gs_val_valid(gs_val_valid), .gs_val(gs_val),
      .coef_we(we2), .coef_addr(addr2), .coef_wdata(wdata2), .rej_cnt(rej2)
   );

   mkgauss_poly_ctrl #(.LOGN(9), .COEF_BITS(8)) dut9 (
      .clk(clk), .rst(rst), .start(start9), .abort(abort),
      .busy(busy9), .done(done9), .gs_ena(ena9),
      .gs_val_valid(gs_val_valid), .gs_val(gs_val),
      .coef_we(we9), .coef_addr(addr9), .coef_wdata(wdata9), .rej_cnt(rej9)
   );

   // Output view of whichever instance a random run is exercising
   logic sel9 = 1'b0;
   int   m_busy, m_ena, m_we, m_addr, m_data, m_done, m_rej;
   always_comb begin
      m_busy = sel9 ? int'(busy9)  : int'(busy2);
      m_ena  = sel9 ? int'(ena9)   : int'(ena2);
      m_we   = sel9 ? int'(we9)    : int'(we2);
      m_addr = sel9 ? int'(addr9)  : int'(addr2);
      m_data = sel9 ? int'(wdata9) : int'(wdata2);
      m_done = sel9 ? int'(done9)  : int'(done2);
      m_rej  = sel9 ? int'(rej9)   : int'(rej2);
   end

   typedef struct {
      logic st;
      logic ab;
      logic vld;
      int   val;
      logic e_busy;
      logic e_ena;
      logic e_we;
      int   e_addr;
      int   e_data;
      logic e_done;
      int   e_rej;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic st, input logic ab, input logic vld, input int val,
                      input logic b, input logic e, input logic w, input int a, input int d,
                      input logic dn, input int r);
      vec_t v;
      v.st = st; v.ab = ab; v.vld = vld; v.val = val;
      v.e_busy = b; v.e_ena = e; v.e_we = w; v.e_addr = a; v.e_data = d;
      v.e_done = dn; v.e_rej = r;
      tbl.push_back(v);
   endtask

   function automatic int gen_val(input int bad_pct);
      int mag;
      if (int'($urandom_range(0, 99)) < bad_pct) begin
         mag = 128 + int'($urandom_range(0, 100000));
         return ($urandom_range(0, 1) == 1) ? mag : -mag;
      end
      return int'($urandom_range(0, 254)) - 127;
   endfunction

   // Randomized runs: the model tracks index, running sum and rejection count arithmetically
   task automatic run_rand(input bit use9, input int runs, input int bad_pct);
      int n;
      int idx, sum, rej, writes, prev_addr, cyc, v;
      bit fin, exp_we, exp_done;
      sel9 = use9;
      n = use9 ? 512 : 4;
      for (int r = 0; r < runs; r++) begin
         if (use9) start9 = 1'b1; else start2 = 1'b1;
         tick();
         start2 = 1'b0; start9 = 1'b0;
         chk("rand_start_busy", m_busy, 1);
         chk("rand_start_rej", m_rej, 0);
         idx = 0; sum = 0; rej = 0; writes = 0; prev_addr = -1; cyc = 0; fin = 1'b0;
         while (!fin && cyc < 20000) begin
            cyc++;
            gs_val_valid = ($urandom_range(0, 3) != 0);
            v = gen_val(bad_pct);
            gs_val = 32'(v);
            exp_we = 1'b0; exp_done = 1'b0;
            if (gs_val_valid) begin
               if (v > 127 || v < -127) rej++;
               else if (idx == n - 1 && ((sum + v) & 1) == 0) rej++;
               else begin
                  exp_we = 1'b1; sum += v; idx++;
                  exp_done = (idx == n);
               end
            end
            tick();
            if (m_we !== int'(exp_we)) chk("rand_we", m_we, int'(exp_we));
            if (exp_we) begin
               writes++;
               chk("rand_addr", m_addr, idx - 1);
               chk("rand_data", m_data, v & 255);
               if (m_addr <= prev_addr) chk("rand_addr_incr", m_addr, prev_addr + 1);
               prev_addr = m_addr;
            end
            if (m_done !== int'(exp_done)) chk("rand_done", m_done, int'(exp_done));
            if (exp_done) fin = 1'b1;
         end
         gs_val_valid = 1'b0;
         chk("rand_finished", int'(fin), 1);
         chk("rand_writes", writes, n);
         chk("rand_sum_odd", sum & 1, 1);
         chk("rand_rej", m_rej, rej);
         chk("rand_ena_off", m_ena, 0);
         tick();
         chk("rand_idle_busy", m_busy, 0);
      end
      sel9 = 1'b0;
   endtask

   initial begin
      // Directed sequences on LOGN=2 (st ab vld val | busy ena we addr data done rej)
      add(1,0,0,0,    1,1,0,0,0,    0,0);
      add(0,0,1,3,    1,1,1,0,'h03, 0,0);
      add(0,0,1,-5,   1,1,1,1,'hFB, 0,0);
      add(0,0,1,0,    1,1,1,2,'h00, 0,0);
      add(0,0,1,2,    1,1,0,0,0,    0,1);
      add(0,0,1,1,    0,0,1,3,'h01, 1,1);
      add(1,0,1,5,    0,0,0,0,0,    0,1);
      add(1,0,0,0,    1,1,0,0,0,    0,0);
      add(0,0,1,127,  1,1,1,0,'h7F, 0,0);
      add(0,0,1,128,  1,1,0,0,0,    0,1);
      add(0,0,1,-128, 1,1,0,0,0,    0,2);
      add(0,0,1,-127, 1,1,1,1,'h81, 0,2);
      add(0,1,0,0,    0,0,0,0,0,    0,2);
      add(0,0,1,1,    0,0,0,0,0,    0,2);
      add(1,0,0,0,    1,1,0,0,0,    0,0);
      add(0,0,1,1,    1,1,1,0,'h01, 0,0);
      add(0,0,1,1,    1,1,1,1,'h01, 0,0);
      add(0,0,1,0,    1,1,1,2,'h00, 0,0);
      add(0,0,1,2,    1,1,0,0,0,    0,1);
      add(0,0,1,4,    1,1,0,0,0,    0,2);
      add(0,0,1,-3,   0,0,1,3,'hFD, 1,2);
      add(0,0,0,0,    0,0,0,0,0,    0,2);
      add(1,0,0,0,    1,1,0,0,0,    0,0);
      add(0,0,1,5,    1,1,1,0,'h05, 0,0);
      add(0,1,1,6,    0,0,0,0,0,    0,0);
      add(0,0,0,0,    0,0,0,0,0,    0,0);
      add(1,0,0,0,    1,1,0,0,0,    0,0);
      add(0,0,1,7,    1,1,1,0,'h07, 0,0);
      add(0,0,1,300,  1,1,0,0,0,    0,1);
      add(1,0,1,9,    1,1,1,1,'h09, 0,1);
      add(0,1,0,0,    0,0,0,0,0,    0,1);
      add(1,1,0,0,    0,0,0,0,0,    0,1);
      add(0,0,0,0,    0,0,0,0,0,    0,1);

      repeat (3) tick();
      chk("rst_busy", int'(busy2), 0);
      chk("rst_done", int'(done2), 0);
      chk("rst_ena", int'(ena2), 0);
      chk("rst_we", int'(we2), 0);
      chk("rst_addr", int'(addr2), 0);
      chk("rst_wdata", int'(wdata2), 0);
      chk("rst_rej", int'(rej2), 0);
      chk("rst_busy9", int'(busy9), 0);
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         start2 = tbl[i].st;
         abort = tbl[i].ab;
         gs_val_valid = tbl[i].vld;
         gs_val = 32'(tbl[i].val);
         tick();
         chk($sformatf("vec%0d_busy", i), int'(busy2), int'(tbl[i].e_busy));
         chk($sformatf("vec%0d_ena", i), int'(ena2), int'(tbl[i].e_ena));
         chk($sformatf("vec%0d_we", i), int'(we2), int'(tbl[i].e_we));
         if (tbl[i].e_we) begin
            chk($sformatf("vec%0d_addr", i), int'(addr2), tbl[i].e_addr);
            chk($sformatf("vec%0d_data", i), int'(wdata2), tbl[i].e_data);
         end
         chk($sformatf("vec%0d_done", i), int'(done2), int'(tbl[i].e_done));
         chk($sformatf("vec%0d_rej", i), int'(rej2), tbl[i].e_rej);
      end
      start2 = 1'b0; abort = 1'b0; gs_val_valid = 1'b0;

      // Asynchronous reset in the middle of a run, checked between clock edges
      start2 = 1'b1; tick(); start2 = 1'b0;
      gs_val_valid = 1'b1; gs_val = 32'd200; tick();
      gs_val = 32'd3; tick();
      gs_val_valid = 1'b0;
      chk("pre_rst_we", int'(we2), 1);
      chk("pre_rst_rej", int'(rej2), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy2), 0);
      chk("arst_ena", int'(ena2), 0);
      chk("arst_we", int'(we2), 0);
      chk("arst_addr", int'(addr2), 0);
      chk("arst_wdata", int'(wdata2), 0);
      chk("arst_done", int'(done2), 0);
      chk("arst_rej", int'(rej2), 0);
      tick();
      rst = 1'b0;
      tick();

      run_rand(1'b0, 20, 20);
      run_rand(1'b1, 2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
